// File: rtl/fir_seq_pkg.sv
// Shared definitions for the chirp-frame FIR sequencer: state encodings and
// default frame geometry used by fir_seq and its watchdog.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        FIR_SEQ_IDLE   = 2'd0,
        FIR_SEQ_FLUSH  = 2'd1,
        FIR_SEQ_WARMUP = 2'd2,
        FIR_SEQ_ACTIVE = 2'd3
    } fir_seq_state_t;

    localparam int FIR_SEQ_NSAMPLES_DEF     = 1024;
    localparam int FIR_SEQ_DISCARD_DEF      = 10;
    localparam int FIR_SEQ_FLUSH_CYCLES_DEF = 24;
    localparam int FIR_SEQ_CNTW_DEF         = 11;
    localparam int FIR_SEQ_TIMEOUT_DEF      = 4096;

    // True while the FIR is released from reset and expected to produce data.
    function automatic logic fir_seq_fir_running(input fir_seq_state_t s);
        return (s == FIR_SEQ_WARMUP) || (s == FIR_SEQ_ACTIVE);
    endfunction

endpackage

// File: rtl/fir_seq_wdog.sv
// Stall watchdog for the FIR sequencer. Counts enabled cycles since the last
// clear and raises expire during the TIMEOUT-th such cycle. Only instantiated
// when FIR_SEQ_TIMEOUT_EN is defined.
module fir_seq_wdog
    import fir_seq_pkg::*;
#(
    parameter int TIMEOUT = FIR_SEQ_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] count;

    // Idle-cycle counter; holds once expired so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && !clear && (count == WW'(TIMEOUT - 1));

endmodule

// File: rtl/fir_seq.sv
// Chirp-frame sequencer sitting between the decimating FIR and the FFT/frame
// buffer. Flushes the FIR between chirps, drops warm-up outputs, passes
// exactly NSAMPLES samples per chirp with sof/eof tags, and flags chirps that
// arrive while a frame is in progress.
// Optional feature: define FIR_SEQ_TIMEOUT_EN to add a stall watchdog that
// abandons the frame after TIMEOUT cycles without FIR output.
module fir_seq
    import fir_seq_pkg::*;
#(
    parameter int OW           = 16,
    parameter int NSAMPLES     = FIR_SEQ_NSAMPLES_DEF,
    parameter int DISCARD      = FIR_SEQ_DISCARD_DEF,
    parameter int FLUSH_CYCLES = FIR_SEQ_FLUSH_CYCLES_DEF,
    parameter int CNTW         = FIR_SEQ_CNTW_DEF
`ifdef FIR_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = FIR_SEQ_TIMEOUT_DEF
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          chirp_start_i,
    input  logic          abort_i,
    output logic          fir_rst_o,
    output logic          fir_ce_o,
    input  logic          fir_dv_i,
    input  logic [OW-1:0] fir_data_i,
    output logic          dv_o,
    output logic [OW-1:0] data_o,
    output logic          sof_o,
    output logic          eof_o,
    output logic          busy_o,
    output logic          overrun_o,
    output logic          timeout_o
);

    fir_seq_state_t  state;
    logic [CNTW-1:0] cnt;
    logic            wdog_expire;

`ifdef FIR_SEQ_TIMEOUT_EN
    logic fir_running;

    assign fir_running = fir_seq_fir_running(state);

    fir_seq_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (fir_dv_i || !fir_running),
        .enable (fir_running),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    // Frame FSM with its shared phase counter; every output is a register so
    // the FIR and downstream buffer see glitch-free, state-aligned controls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FIR_SEQ_IDLE;
            cnt       <= '0;
            fir_rst_o <= 1'b1;
            fir_ce_o  <= 1'b0;
            dv_o      <= 1'b0;
            data_o    <= '0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            dv_o      <= 1'b0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
            if (abort_i || wdog_expire) begin
                state     <= FIR_SEQ_IDLE;
                cnt       <= '0;
                fir_rst_o <= 1'b1;
                fir_ce_o  <= 1'b0;
                busy_o    <= 1'b0;
                timeout_o <= !abort_i && wdog_expire;
            end else begin
                overrun_o <= chirp_start_i && (state != FIR_SEQ_IDLE);
                case (state)
                    FIR_SEQ_IDLE: begin
                        if (chirp_start_i) begin
                            state  <= FIR_SEQ_FLUSH;
                            cnt    <= '0;
                            busy_o <= 1'b1;
                        end
                    end
                    FIR_SEQ_FLUSH: begin
                        if (cnt == CNTW'(FLUSH_CYCLES - 1)) begin
                            state     <= (DISCARD == 0) ? FIR_SEQ_ACTIVE : FIR_SEQ_WARMUP;
                            cnt       <= '0;
                            fir_rst_o <= 1'b0;
                            fir_ce_o  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    FIR_SEQ_WARMUP: begin
                        if (fir_dv_i) begin
                            if (cnt == CNTW'(DISCARD - 1)) begin
                                state <= FIR_SEQ_ACTIVE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    FIR_SEQ_ACTIVE: begin
                        if (fir_dv_i) begin
                            dv_o   <= 1'b1;
                            data_o <= fir_data_i;
                            sof_o  <= (cnt == '0);
                            eof_o  <= (cnt == CNTW'(NSAMPLES - 1));
                            if (cnt == CNTW'(NSAMPLES - 1)) begin
                                state     <= FIR_SEQ_IDLE;
                                cnt       <= '0;
                                fir_rst_o <= 1'b1;
                                fir_ce_o  <= 1'b0;
                                busy_o    <= 1'b0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= FIR_SEQ_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
